// File: rtl/vga_pixel_feeder.sv
// rtl/vga_pixel_feeder.sv - registers VGA sync/de, feeds line-buffer pixels, tracks x/y and underflow.
// Optional frame-geometry checker enabled by defining VGA_FEEDER_CHECK_EN.
module vga_pixel_feeder #(
    parameter int   H_ACTIVE = 1024,
    parameter int   V_ACTIVE = 768,
    parameter int   DATA_W   = 24,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              underflow_clr,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [DATA_W-1:0] rgb_out,
    output logic [11:0]       x_pos,
    output logic [11:0]       y_pos,
    output logic              frame_start,
    output logic              underflow,
    output logic              geometry_err
);

    typedef enum logic [1:0] {IDLE, STREAM, RESYNC} state_t;

    localparam logic [11:0] POS_MAX = 12'hFFF;

    state_t state;
    state_t state_nxt;
    logic   vs_prev;
    logic   vs_edge;
    logic   de_fall;
    logic   uf_evt;

    assign vs_edge   = (vs_prev != VS_POL) && (vs_in == VS_POL);
    assign de_fall   = de_out && !de_in;
    assign pix_ready = de_in && pix_valid && (state == STREAM);
    assign uf_evt    = de_in && !pix_valid && (state == STREAM);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_edge) state_nxt = STREAM;
            STREAM:  if (uf_evt)  state_nxt = RESYNC;
            RESYNC:  if (vs_edge) state_nxt = STREAM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_prev     <= VS_POL;
            hs_out      <= ~HS_POL;
            vs_out      <= ~VS_POL;
            de_out      <= 1'b0;
            rgb_out     <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_nxt;
            vs_prev     <= vs_in;
            hs_out      <= hs_in;
            vs_out      <= vs_in;
            de_out      <= de_in;
            rgb_out     <= pix_ready ? pix_data : '0;
            frame_start <= vs_edge;
            // de_out is last cycle's de_in, so a low value marks the first pixel of a line
            if (de_in) begin
                if (!de_out)
                    x_pos <= '0;
                else if (x_pos != POS_MAX)
                    x_pos <= x_pos + 12'd1;
            end
            if (vs_edge)
                y_pos <= '0;
            else if (de_fall && (y_pos != POS_MAX))
                y_pos <= y_pos + 12'd1;
            if (uf_evt)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;
        end
    end

`ifdef VGA_FEEDER_CHECK_EN
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        vs_seen;
    logic        geom_flag;

    // The first vs edge after reset follows an unknown partial frame, so it is not judged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            vs_seen   <= 1'b0;
            geom_flag <= 1'b0;
        end else begin
            if (de_in)
                h_cnt <= de_out ? h_cnt + 16'd1 : 16'd1;
            if (de_fall && (h_cnt != 16'(H_ACTIVE)))
                geom_flag <= 1'b1;
            if (vs_edge) begin
                if (vs_seen && (v_cnt != 16'(V_ACTIVE)))
                    geom_flag <= 1'b1;
                vs_seen <= 1'b1;
                v_cnt   <= '0;
            end else if (de_fall) begin
                v_cnt <= v_cnt + 16'd1;
            end
        end
    end

    assign geometry_err = geom_flag;
`else
    assign geometry_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb/tb_vga_pixel_feeder.sv - directed self-checking bench for vga_pixel_feeder on a small 8x4 raster.
module tb_vga_pixel_feeder;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LT = H + 4;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hs_in = 1'b1;
    logic          vs_in = 1'b0;
    logic          de_in = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          underflow_clr = 1'b0;
    logic          hs_out;
    logic          vs_out;
    logic          de_out;
    logic [DW-1:0] rgb_out;
    logic [11:0]   x_pos;
    logic [11:0]   y_pos;
    logic          frame_start;
    logic          underflow;
    logic          geometry_err;

    int total = 0;
    int bad   = 0;
    int seed  = 1;
    int n     = 0;

    always #5 clk = ~clk;

    vga_pixel_feeder #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .underflow_clr(underflow_clr), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
        .rgb_out(rgb_out), .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
        .underflow(underflow), .geometry_err(geometry_err)
    );

    task automatic check_reset_vals(input string tag);
        total++;
        if ({hs_out, vs_out, de_out, rgb_out, x_pos, y_pos, frame_start, underflow, geometry_err}
            !== {1'b1, 1'b1, 1'b0, 24'h0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL %s: hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d fs=%b uf=%b ge=%b, want reset values",
                     tag, hs_out, vs_out, de_out, rgb_out, x_pos, y_pos, frame_start, underflow, geometry_err);
        end
    endtask

    // One raster frame: 2 vsync lines, 1 back-porch line, V active lines of H pixels.
    task automatic run_frame(input int drop_line, input int drop_px, input bit clr_at_drop,
                             input bit uf_before, input int abort_at, output int xfers);
        bit stream = 1'b1;
        bit uf = uf_before;
        int cyc = 0;
        xfers = 0;
        for (int l = 0; l < V + 3; l++) begin
            for (int c = 0; c < LT; c++) begin
                bit act, hs, vs, valid, clr, exp_rdy;
                logic [DW-1:0] d, exp_rgb;
                int y;
                if (cyc == abort_at) return;
                y     = l - 3;
                vs    = (l >= 2);
                act   = (l >= 3) && (c < H);
                hs    = !(c == H + 1 || c == H + 2);
                valid = !(act && y == drop_line && c == drop_px);
                clr   = clr_at_drop && !valid;
                d     = {8'(seed), 8'(c ^ y), 8'(c)};
                @(negedge clk);
                hs_in = hs; vs_in = vs; de_in = act; pix_valid = valid; pix_data = d;
                underflow_clr = clr;
                #1;
                exp_rdy = act && valid && stream;
                total++;
                if (pix_ready !== exp_rdy) begin
                    bad++;
                    $display("FAIL pix_ready l=%0d c=%0d: got %b want %b", l, c, pix_ready, exp_rdy);
                end
                if (exp_rdy) xfers++;
                exp_rgb = exp_rdy ? d : '0;
                if (act && !valid && stream) begin
                    stream = 1'b0;
                    uf = 1'b1;
                end else if (clr) begin
                    uf = 1'b0;
                end
                @(posedge clk);
                #1;
                total++;
                if ({hs_out, vs_out, de_out, rgb_out, frame_start, underflow}
                    !== {hs, vs, act, exp_rgb, cyc == 0, uf}) begin
                    bad++;
                    $display("FAIL frame_out l=%0d c=%0d: hs=%b vs=%b de=%b rgb=%h fs=%b uf=%b want %b %b %b %h %b %b",
                             l, c, hs_out, vs_out, de_out, rgb_out, frame_start, underflow,
                             hs, vs, act, exp_rgb, cyc == 0, uf);
                end
                if (act) begin
                    total++;
                    if (x_pos !== 12'(c) || y_pos !== 12'(y)) begin
                        bad++;
                        $display("FAIL xy: got (%0d,%0d) want (%0d,%0d)", x_pos, y_pos, c, y);
                    end
                end
                cyc++;
            end
        end
        underflow_clr = 1'b0;
        seed++;
    endtask

    // Active-looking lines with vs inactive; feeder is not streaming, so nothing may transfer.
    task automatic idle_lines(input int lines);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < LT; c++) begin
                @(negedge clk);
                hs_in = 1'b1; vs_in = 1'b1; de_in = (c < H); pix_valid = 1'b1;
                pix_data = 24'hABCDEF;
                #1;
                total++;
                if (pix_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_ready: got %b want 0", pix_ready);
                end
                @(posedge clk);
                #1;
                total++;
                if ({de_out, rgb_out, frame_start} !== {(c < H), 24'h0, 1'b0}) begin
                    bad++;
                    $display("FAIL idle_out c=%0d: de=%b rgb=%h fs=%b want %b 0 0",
                             c, de_out, rgb_out, frame_start, (c < H));
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vs_in = 1'b0; hs_in = 1'b1; de_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (frame_start !== 1'b0 || vs_out !== 1'b0) begin
                bad++;
                $display("FAIL vs_held: fs=%b vs_out=%b want 0 0", frame_start, vs_out);
            end
        end
        idle_lines(1);
    endtask

    task automatic test_stream;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, -1, 1'b0, 1'b0, -1, n);
            total++;
            if (n != H * V) begin
                bad++;
                $display("FAIL stream_xfers: got %0d want %0d", n, H * V);
            end
        end
    endtask

    task automatic test_underflow;
        run_frame(2, 5, 1'b0, 1'b0, -1, n);
        total++;
        if (n != 2 * H + 5) begin
            bad++;
            $display("FAIL uf_xfers: got %0d want %0d", n, 2 * H + 5);
        end
        run_frame(-1, -1, 1'b0, 1'b1, -1, n);
        total++;
        if (n != H * V) begin
            bad++;
            $display("FAIL resync_xfers: got %0d want %0d", n, H * V);
        end
    endtask

    task automatic test_clr_collision;
        run_frame(1, 3, 1'b1, 1'b1, -1, n);
        total++;
        if (n != H + 3) begin
            bad++;
            $display("FAIL collide_xfers: got %0d want %0d", n, H + 3);
        end
        @(negedge clk);
        vs_in = 1'b1; de_in = 1'b0; underflow_clr = 1'b1;
        @(posedge clk);
        #1;
        underflow_clr = 1'b0;
        total++;
        if (underflow !== 1'b0) begin
            bad++;
            $display("FAIL uf_clear: got %b want 0", underflow);
        end
        run_frame(-1, -1, 1'b0, 1'b0, -1, n);
        total++;
        if (n != H * V) begin
            bad++;
            $display("FAIL after_clr_xfers: got %0d want %0d", n, H * V);
        end
    endtask

    task automatic test_reset_midframe;
        run_frame(-1, -1, 1'b0, 1'b0, 3 * LT + 4, n);
        @(negedge clk);
        hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b1; pix_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_vals("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_lines(2);
        run_frame(-1, -1, 1'b0, 1'b0, -1, n);
        total++;
        if (n != H * V) begin
            bad++;
            $display("FAIL post_reset_xfers: got %0d want %0d", n, H * V);
        end
    endtask

    task automatic test_geometry;
        bit exp_ge;
`ifdef VGA_FEEDER_CHECK_EN
        exp_ge = 1'b1;
`else
        exp_ge = 1'b0;
`endif
        total++;
        if (geometry_err !== 1'b0) begin
            bad++;
            $display("FAIL geom_clean: got %b want 0", geometry_err);
        end
        for (int c = 0; c < H + 4; c++) begin
            @(negedge clk);
            hs_in = 1'b1; vs_in = 1'b1; de_in = (c < H + 2); pix_valid = 1'b1;
        end
        @(negedge clk);
        de_in = 1'b0;
        #1;
        total++;
        if (geometry_err !== exp_ge) begin
            bad++;
            $display("FAIL geom_long_line: got %b want %b", geometry_err, exp_ge);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_clr_collision();
        test_reset_midframe();
        test_geometry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
